// File: rtl/float_pkg.sv
// Shared float-word helpers: default widths, field-position helpers, canonical quiet NaN, reduction FSM states.
// No logic; constant functions only.
package float_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_EXP_W   = 8;
    localparam int DEF_LEN_W   = 16;
    localparam int DEF_DELAY_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ACC   = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Mantissa width; the exponent sits directly above it and the sign is the MSB.
    function automatic int man_w(input int data_w, input int exp_w);
        return data_w - exp_w - 1;
    endfunction

    // Sign 0, exponent all ones, mantissa MSB set (0x7FC00000 at 32/8).
    function automatic logic [63:0] qnan(input int data_w, input int exp_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= man_w(data_w, exp_w) && i < data_w - 1) begin
                r[i] = 1'b1;
            end
        end
        r[man_w(data_w, exp_w) - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/float_argmax_accum_if.sv
// Stream and config bundle for the float argmax reduction unit.
// Plain wires; no flow control beyond the global running enable.
interface float_argmax_accum_if
    import float_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int DELAY_W = DEF_DELAY_W
);
    logic               running;
    logic               run;
    logic [DATA_W-1:0]  in0;
    logic [LEN_W-1:0]   length;
    logic [DELAY_W-1:0] delay0;
    logic [DATA_W-1:0]  out0;
    logic [LEN_W-1:0]   out1;
    logic               done;

    modport master (
        output running, run, in0, length, delay0,
        input  out0, out1, done
    );

    modport slave (
        input  running, run, in0, length, delay0,
        output out0, out1, done
    );
endinterface

// File: rtl/float_gt_cmp.sv
// Combinational strict sign-magnitude greater-than (a > b) and NaN detect on a.
// Zero latency; no handshake.
module float_gt_cmp
    import float_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              a_gt_b,
    output logic              a_nan
);
    localparam int MAN_W = man_w(DATA_W, EXP_W);

    logic              sign_a;
    logic              sign_b;
    logic [DATA_W-2:0] mag_a;
    logic [DATA_W-2:0] mag_b;

    always_comb begin
        sign_a = a[DATA_W-1];
        sign_b = b[DATA_W-1];
        mag_a  = a[DATA_W-2:0];
        mag_b  = b[DATA_W-2:0];
        a_nan  = (&a[DATA_W-2:MAN_W]) && (|a[MAN_W-1:0]);
        // Differing signs: the positive one wins, so +0 > -0 falls out naturally.
        if (sign_a != sign_b) begin
            a_gt_b = !sign_a;
        end else if (sign_a) begin
            a_gt_b = mag_a < mag_b;
        end else begin
            a_gt_b = mag_a > mag_b;
        end
    end
endmodule

// File: rtl/float_argmax_accum.sv
// Streaming argmax over a configured window of floats; out0/out1 registered, 1-cycle latency per element.
// No backpressure: one element per cycle while running; running=0 freezes all state.
module float_argmax_accum
    import float_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int EXP_W   = DEF_EXP_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int DELAY_W = DEF_DELAY_W
) (
    input  logic clk,
    input  logic rst,
    float_argmax_accum_if.slave bus
);
    localparam logic [DATA_W-1:0] QNAN_VAL = DATA_W'(qnan(DATA_W, EXP_W));

    state_t             state, state_n;
    logic [DELAY_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0]   idx, idx_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               found, found_n;
    logic [DATA_W-1:0]  out0_q, out0_n;
    logic [LEN_W-1:0]   out1_q, out1_n;
    logic               done_q, done_n;
    logic               x_gt;
    logic               x_nan;

    float_gt_cmp #(
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W)
    ) u_cmp (
        .a      (bus.in0),
        .b      (out0_q),
        .a_gt_b (x_gt),
        .a_nan  (x_nan)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            len_q  <= '0;
            found  <= 1'b0;
            out0_q <= '0;
            out1_q <= '0;
            done_q <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            len_q  <= len_n;
            found  <= found_n;
            out0_q <= out0_n;
            out1_q <= out1_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        len_n   = len_q;
        found_n = found;
        out0_n  = out0_q;
        out1_n  = out1_q;
        done_n  = done_q;
        if (bus.running) begin
            // A run pulse in any state discards whatever reduction was in flight.
            if (bus.run) begin
                len_n   = bus.length;
                found_n = 1'b0;
                done_n  = 1'b0;
                idx_n   = '0;
                if (bus.delay0 != '0) begin
                    state_n = DELAY;
                    cnt_n   = bus.delay0 - DELAY_W'(1);
                end else if (bus.length != '0) begin
                    state_n = ACC;
                end else begin
                    state_n = FIN;
                end
            end else begin
                case (state)
                    DELAY: begin
                        if (cnt == '0) begin
                            state_n = (len_q == '0) ? FIN : ACC;
                        end else begin
                            cnt_n = cnt - DELAY_W'(1);
                        end
                    end
                    ACC: begin
                        if (!x_nan && (!found || x_gt)) begin
                            out0_n  = bus.in0;
                            out1_n  = idx;
                            found_n = 1'b1;
                        end
                        if (idx == len_q - LEN_W'(1)) begin
                            state_n = FIN;
                        end else begin
                            idx_n = idx + LEN_W'(1);
                        end
                    end
                    FIN: begin
                        if (!found) begin
                            out0_n = QNAN_VAL;
                            out1_n = '1;
                        end
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out0 = out0_q;
    assign bus.out1 = out1_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_float_argmax_accum.sv
// Bench for float_argmax_accum: scoreboarded windows checked when done rises.
module tb_float_argmax_accum;
    localparam logic [31:0] JUNK = 32'h7F7F_FFFF;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [47:0] exp_q[$];

    float_argmax_accum_if #(.DATA_W(32), .LEN_W(16), .DELAY_W(8)) bus ();

    float_argmax_accum #(
        .DATA_W  (32),
        .EXP_W   (8),
        .LEN_W   (16),
        .DELAY_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Order-preserving key: unsigned compare of keys equals float compare.
    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic void model(input logic [31:0] v[$], output logic [31:0] mx, output logic [15:0] ix);
        bit f;
        logic nan;
        f  = 1'b0;
        mx = 32'h7FC0_0000;
        ix = 16'hFFFF;
        foreach (v[i]) begin
            nan = (v[i][30:23] == 8'hFF) && (v[i][22:0] != 23'd0);
            if (!nan && (!f || fkey(v[i]) > fkey(mx))) begin
                mx = v[i];
                ix = 16'(i);
                f  = 1'b1;
            end
        end
    endfunction

    task automatic do_run(input string tag, input int d, input logic [31:0] v[$],
                          input int gate_at, input int gate_n);
        logic [31:0] em;
        logic [15:0] ei;
        logic [47:0] e;
        int cyc;
        int n;
        int g;
        model(v, em, ei);
        exp_q.push_back({em, ei});
        g = (gate_at >= 0 && gate_at < v.size()) ? gate_n : 0;
        bus.run    = 1'b1;
        bus.delay0 = 8'(d);
        bus.length = 16'(v.size());
        bus.in0    = JUNK;
        tick();
        cyc = 1;
        bus.run    = 1'b0;
        bus.delay0 = 8'hFF;
        bus.length = 16'h0009;
        chk({tag, "_busy"}, 64'(bus.done), 64'd0);
        repeat (d) begin
            tick();
            cyc++;
        end
        foreach (v[i]) begin
            bus.in0 = v[i];
            if (i == gate_at) begin
                bus.running = 1'b0;
                repeat (gate_n) begin
                    tick();
                    cyc++;
                end
                bus.running = 1'b1;
            end
            tick();
            cyc++;
        end
        bus.in0 = JUNK;
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            cyc++;
            n++;
        end
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_lat"}, 64'(cyc), 64'(2 + d + v.size() + g));
        e = exp_q.pop_front();
        chk({tag, "_max"}, 64'(bus.out0), 64'(e[47:16]));
        chk({tag, "_idx"}, 64'(bus.out1), 64'(e[15:0]));
        tick();
        chk({tag, "_hold"}, 64'({bus.done, bus.out0, bus.out1}), 64'({1'b1, e}));
    endtask

    logic [31:0] q[$];
    logic [31:0] specials[8];

    initial begin
        total = 0;
        bad   = 0;
        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0001, 32'h3F80_0000, 32'hBF80_0000, 32'h4060_0000};
        rst         = 1'b1;
        bus.running = 1'b1;
        bus.run     = 1'b0;
        bus.in0     = '0;
        bus.length  = '0;
        bus.delay0  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out0", 64'(bus.out0), 64'd0);
        chk("rst_out1", 64'(bus.out1), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd1);

        // run while not running must not start anything
        bus.running = 1'b0;
        bus.run     = 1'b1;
        bus.length  = 16'd3;
        tick();
        bus.run     = 1'b0;
        bus.running = 1'b1;
        tick();
        chk("gated_run", 64'(bus.done), 64'd1);

        q = '{32'h3F80_0000, 32'h4060_0000, 32'hC000_0000, 32'h4000_0000};
        do_run("basic", 0, q, -1, 0);
        q = '{32'hBFC0_0000, 32'hBFC0_0000, 32'hC040_0000};
        do_run("ties", 0, q, -1, 0);
        q = '{32'h7FC0_0001, 32'h8000_0000, 32'h0000_0000};
        do_run("zero", 0, q, -1, 0);
        q = '{32'h7FC0_0001, 32'hFF80_0001};
        do_run("allnan", 0, q, -1, 0);
        q = '{32'hC100_0000, 32'h4100_0000};
        do_run("delay", 3, q, -1, 0);
        q = '{32'h4100_0000, 32'hC100_0000, 32'h4080_0000};
        do_run("gate", 0, q, 1, 2);
        q.delete();
        do_run("len0", 0, q, -1, 0);
        q.delete();
        do_run("len0d", 2, q, -1, 0);

        // restart mid-ACC: the second run must forget the larger earlier elements
        bus.run    = 1'b1;
        bus.delay0 = 8'd0;
        bus.length = 16'd4;
        tick();
        bus.run = 1'b0;
        bus.in0 = 32'h7F00_0000;
        tick();
        tick();
        bus.run    = 1'b1;
        bus.length = 16'd1;
        tick();
        bus.run    = 1'b0;
        bus.length = 16'd9;
        bus.in0    = 32'h40A0_0000;
        tick();
        bus.in0 = JUNK;
        chk("restart_busy", 64'(bus.done), 64'd0);
        tick();
        chk("restart_done", 64'(bus.done), 64'd1);
        chk("restart_max", 64'(bus.out0), 64'h40A0_0000);
        chk("restart_idx", 64'(bus.out1), 64'd0);

        // reset after two accepted elements
        bus.run    = 1'b1;
        bus.delay0 = 8'd0;
        bus.length = 16'd4;
        tick();
        bus.run = 1'b0;
        bus.in0 = 32'h3F80_0000;
        tick();
        bus.in0 = 32'h4000_0000;
        tick();
        rst     = 1'b1;
        bus.in0 = 32'h4040_0000;
        tick();
        rst     = 1'b0;
        bus.in0 = JUNK;
        chk("mrst_out0", 64'(bus.out0), 64'd0);
        chk("mrst_out1", 64'(bus.out1), 64'd0);
        chk("mrst_done", 64'(bus.done), 64'd1);
        tick();
        tick();
        chk("mrst_idle", 64'({bus.done, bus.out0, bus.out1}), 64'({1'b1, 32'd0, 16'd0}));
        q = '{32'h3F80_0000, 32'h4060_0000, 32'hC000_0000, 32'h4000_0000};
        do_run("after_rst", 0, q, -1, 0);

        for (int w = 0; w < 8; w++) begin
            int len;
            len = $urandom_range(1, 6);
            q.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    q.push_back(specials[$urandom_range(0, 7)]);
                end else begin
                    q.push_back($urandom());
                end
            end
            do_run("rand", $urandom_range(0, 2), q, ($urandom_range(0, 1) == 1) ? 0 : -1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
